cordic_vectoring_seq: RTL and testbench

//  Iterative vectoring-mode CORDIC: the inverse of the rotation-mode CORDIC trig unit. Takes a

---
 rtl/cordic_pkg.sv | 73 +++++++
 rtl/cordic_vec_stage.sv | 47 ++++
 rtl/cordic_vectoring_seq.sv | 182 ++++++++++++++++++
 tb/tb_cordic_vectoring_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Constants and helpers shared by the CORDIC rotation and vectoring units.
//   - atanQ30()   : arctangent table atan(2^-i), 32 entries, Q2.30
//   - PI_Q30      : pi in Q3.30
//   - PI_2_Q30    : pi/2 in Q2.30
//   - INV_K_Q30   : 1/K (CORDIC gain reciprocal) in Q2.30
//   - scaleQ30()  : rescales a Q*.30 constant to another fraction width
//   - cordicState_t : FSM state encoding for the sequential units
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int TABLE_FRAC = 30;

    localparam logic [35:0] PI_Q30    = 36'h0C90FDAA2;
    localparam logic [31:0] PI_2_Q30  = 32'h6487ED51;
    localparam logic [31:0] INV_K_Q30 = 32'h26DD3B6A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ITER = 3'd2,
        ST_GAIN = 3'd3,
        ST_DONE = 3'd4
    } cordicState_t;

    // atan(2^-idx) scaled by 2^30 and rounded; entries beyond the table are zero.
    function automatic logic [31:0] atanQ30(input int idx);
        case (idx)
            0:  return 32'h3243F6A9;
            1:  return 32'h1DAC6705;
            2:  return 32'h0FADBAFD;
            3:  return 32'h07F56EA7;
            4:  return 32'h03FEAB77;
            5:  return 32'h01FFD55C;
            6:  return 32'h00FFFAAB;
            7:  return 32'h007FFF55;
            8:  return 32'h003FFFEB;
            9:  return 32'h001FFFFD;
            10: return 32'h00100000;
            11: return 32'h00080000;
            12: return 32'h00040000;
            13: return 32'h00020000;
            14: return 32'h00010000;
            15: return 32'h00008000;
            16: return 32'h00004000;
            17: return 32'h00002000;
            18: return 32'h00001000;
            19: return 32'h00000800;
            20: return 32'h00000400;
            21: return 32'h00000200;
            22: return 32'h00000100;
            23: return 32'h00000080;
            24: return 32'h00000040;
            25: return 32'h00000020;
            26: return 32'h00000010;
            27: return 32'h00000008;
            28: return 32'h00000004;
            29: return 32'h00000002;
            30: return 32'h00000001;
            default: return 32'h00000000;
        endcase
    endfunction

    // Table constants carry 30 fraction bits; other word widths shift them into place.
    function automatic logic signed [63:0] scaleQ30(input logic signed [63:0] v, input int fracBits);
        if (fracBits >= TABLE_FRAC) begin
            return v <<< (fracBits - TABLE_FRAC);
        end
        return v >>> (TABLE_FRAC - fracBits);
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// ---------------------------------------------------------------------------
// cordic_vec_stage
// Combinational single vectoring-mode micro-rotation. Drives y toward zero
// and accumulates the rotated angle in z.
// Parameters: IW internal word width, FRAC fraction bits, IDXW index width.
// Ports:
//   xIn, yIn, zIn     : current vector and angle accumulator (signed, IW bits)
//   idx               : micro-rotation index i (shift amount, table index)
//   xOut, yOut, zOut  : values after the micro-rotation
// ---------------------------------------------------------------------------
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int IW   = 35,
    parameter int FRAC = 30,
    parameter int IDXW = 5
) (
    input  logic signed [IW-1:0] xIn,
    input  logic signed [IW-1:0] yIn,
    input  logic signed [IW-1:0] zIn,
    input  logic [IDXW-1:0]      idx,
    output logic signed [IW-1:0] xOut,
    output logic signed [IW-1:0] yOut,
    output logic signed [IW-1:0] zOut
);

    logic signed [IW-1:0] xShift;
    logic signed [IW-1:0] yShift;
    logic signed [IW-1:0] atanVal;

    // Both updates use the pre-step x and y; the sign of y picks the rotation direction.
    always_comb begin
        xShift  = xIn >>> idx;
        yShift  = yIn >>> idx;
        atanVal = IW'(scaleQ30(signed'({32'b0, atanQ30(int'(idx))}), FRAC));
        if (!yIn[IW-1]) begin
            xOut = xIn + yShift;
            yOut = yIn - xShift;
            zOut = zIn + atanVal;
        end else begin
            xOut = xIn - yShift;
            yOut = yIn + xShift;
            zOut = zIn - atanVal;
        end
    end

endmodule

// File: rtl/cordic_vectoring_seq.sv
// ---------------------------------------------------------------------------
// cordic_vectoring_seq
// Iterative vectoring-mode CORDIC: converts a Q2.(WIDTH-2) Cartesian vector
// into its angle atan2(y,x) and magnitude, one micro-rotation per clock.
// Optional macro: CORDIC_GAIN_COMP_EN adds a GAIN cycle that multiplies the
// magnitude by 1/K so mag_out is the true |v|; without it mag_out = K*|v|.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   start    : job request, accepted only while ready=1
//   x_in     : signed Q2.(WIDTH-2) x component
//   y_in     : signed Q2.(WIDTH-2) y component
//   ready    : 1 while idle
//   valid    : one-cycle pulse when ang_out/mag_out update
//   ang_out  : signed Q3.(WIDTH-2) angle in radians, [-pi, pi]
//   mag_out  : unsigned Q4.(WIDTH-2) magnitude
// ---------------------------------------------------------------------------
module cordic_vectoring_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    ready,
    output logic                    valid,
    output logic signed [WIDTH:0]   ang_out,
    output logic [WIDTH+1:0]        mag_out
);

    // Three guard bits keep the -2.0 corner and the K gain (up to ~4.66) in range.
    localparam int IW   = WIDTH + 3;
    localparam int FRAC = WIDTH - 2;
    localparam int IDXW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [IW-1:0] HALF_PI = IW'(scaleQ30(signed'(64'(PI_2_Q30)), FRAC));

    cordicState_t         state;
    cordicState_t         stateNext;
    logic signed [IW-1:0] xReg;
    logic signed [IW-1:0] yReg;
    logic signed [IW-1:0] zReg;
    logic [IDXW-1:0]      iterIdx;
    logic                 zeroVec;

    logic signed [IW-1:0] preX;
    logic signed [IW-1:0] preY;
    logic signed [IW-1:0] preZ;
    logic signed [IW-1:0] xStep;
    logic signed [IW-1:0] yStep;
    logic signed [IW-1:0] zStep;

    cordic_vec_stage #(
        .IW   (IW),
        .FRAC (FRAC),
        .IDXW (IDXW)
    ) stage (
        .xIn  (xReg),
        .yIn  (yReg),
        .zIn  (zReg),
        .idx  (iterIdx),
        .xOut (xStep),
        .yOut (yStep),
        .zOut (zStep)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [IW-1:0] INV_K = IW'(scaleQ30(signed'(64'(INV_K_Q30)), FRAC));

    logic signed [2*IW-1:0] gainProd;
    logic signed [IW-1:0]   gainX;

    // x is non-negative after the iterations, so truncating the shifted product floors |v|.
    always_comb begin
        gainProd = (2*IW)'(xReg) * (2*IW)'(INV_K);
        gainX    = IW'(gainProd >>> FRAC);
    end
`endif

    // Left-half-plane vectors are pre-rotated by +/-90 degrees into the
    // right half plane, where the micro-rotations converge.
    always_comb begin
        preX = xReg;
        preY = yReg;
        preZ = zReg;
        if (xReg[IW-1]) begin
            if (!yReg[IW-1]) begin
                preX = yReg;
                preY = -xReg;
                preZ = HALF_PI;
            end else begin
                preX = -yReg;
                preY = xReg;
                preZ = -HALF_PI;
            end
        end
    end

    // Next-state logic; ready is simply "in IDLE".
    always_comb begin
        stateNext = state;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    stateNext = ST_PRE;
                end
            end
            ST_PRE: stateNext = ST_ITER;
            ST_ITER: begin
                if (iterIdx == IDXW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    stateNext = ST_GAIN;
`else
                    stateNext = ST_DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_GAIN: stateNext = ST_DONE;
`endif
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Datapath registers and outputs. A zero vector never steers y, so it would
    // accumulate the whole atan table; zeroVec forces its angle to 0 instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            xReg    <= '0;
            yReg    <= '0;
            zReg    <= '0;
            iterIdx <= '0;
            zeroVec <= 1'b0;
            valid   <= 1'b0;
            ang_out <= '0;
            mag_out <= '0;
        end else begin
            state <= stateNext;
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xReg    <= IW'(x_in);
                        yReg    <= IW'(y_in);
                        zReg    <= '0;
                        iterIdx <= '0;
                        zeroVec <= (x_in == '0) && (y_in == '0);
                    end
                end
                ST_PRE: begin
                    xReg <= preX;
                    yReg <= preY;
                    zReg <= preZ;
                end
                ST_ITER: begin
                    xReg    <= xStep;
                    yReg    <= yStep;
                    zReg    <= zStep;
                    iterIdx <= iterIdx + 1'b1;
                end
`ifdef CORDIC_GAIN_COMP_EN
                ST_GAIN: xReg <= gainX;
`endif
                ST_DONE: begin
                    ang_out <= zeroVec ? '0 : zReg[WIDTH:0];
                    mag_out <= xReg[WIDTH+1:0];
                    valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_seq.sv
// ---------------------------------------------------------------------------
// tb_cordic_vectoring_seq
// Directed self-checking bench for cordic_vectoring_seq (WIDTH=32, ITER=30).
// Expected angles are hand constants or the generating angle; expected
// magnitudes come from sqrt(x^2+y^2), scaled by K unless gain compensation
// is built in (CORDIC_GAIN_COMP_EN).
// ---------------------------------------------------------------------------
module tb_cordic_vectoring_seq;

    localparam int    WIDTH   = 32;
    localparam int    ITER    = 30;
    localparam int    TIMEOUT = 200;
    localparam real   PI_R    = 3.14159265358979323846;
    localparam real   SCALE   = 1073741824.0;
    localparam longint PI_LSB = 64'sh0C90FDAA2;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT    = ITER + 2 + EXTRA;
    localparam int PERIOD = ITER + 3 + EXTRA;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic signed [WIDTH-1:0] xIn;
    logic signed [WIDTH-1:0] yIn;
    logic                    ready;
    logic                    valid;
    logic signed [WIDTH:0]   angOut;
    logic [WIDTH+1:0]        magOut;

    int  checks;
    int  errors;
    real magGain;

    cordic_vectoring_seq #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x_in    (xIn),
        .y_in    (yIn),
        .ready   (ready),
        .valid   (valid),
        .ang_out (angOut),
        .mag_out (magOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected, input longint tol);
        longint diff;
        checks++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, presents one request for exactly the accepting edge.
    task automatic applyStimulus(input logic signed [WIDTH-1:0] xv, input logic signed [WIDTH-1:0] yv);
        int guard;
        guard = 0;
        while (!ready && guard < TIMEOUT) begin
            stepClock();
            guard++;
        end
        xIn   = xv;
        yIn   = yv;
        start = 1'b1;
        stepClock();
        start = 1'b0;
    endtask

    // Counts edges until valid is seen; returns TIMEOUT if it never comes.
    task automatic waitValid(output int lat);
        lat = 0;
        while (!valid && lat < TIMEOUT) begin
            stepClock();
            lat++;
        end
    endtask

    function automatic longint expMag(input logic signed [WIDTH-1:0] xv, input logic signed [WIDTH-1:0] yv);
        real xr;
        real yr;
        xr = real'(xv);
        yr = real'(yv);
        return longint'($sqrt(xr * xr + yr * yr) * magGain);
    endfunction

    function automatic longint radToLsb(input real rad);
        return longint'(rad * SCALE);
    endfunction

    // Runs one job and checks latency, angle and magnitude.
    task automatic runVector(input string tag, input logic signed [WIDTH-1:0] xv,
                             input logic signed [WIDTH-1:0] yv, input longint angExp,
                             input longint angTol, input longint magTol);
        int lat;
        applyStimulus(xv, yv);
        waitValid(lat);
        checkOutput({tag, "Lat"}, longint'(lat), longint'(LAT), 0);
        checkOutput({tag, "Ang"}, longint'(angOut), angExp, angTol);
        checkOutput({tag, "Mag"}, longint'(magOut), expMag(xv, yv), magTol);
    endtask

    initial begin
        int  lat;
        int  seen;
        int  firstAt;
        int  secondAt;
        real p;
        real rad;
        logic signed [WIDTH-1:0] xv;
        logic signed [WIDTH-1:0] yv;
        longint angExp;
        longint diff;

        checks = 0;
        errors = 0;
`ifdef CORDIC_GAIN_COMP_EN
        magGain = 1.0;
`else
        magGain = 1.0;
        p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            magGain = magGain * $sqrt(1.0 + p);
            p = p / 4.0;
        end
`endif

        reset = 1'b1;
        start = 1'b0;
        xIn   = '0;
        yIn   = '0;
        repeat (3) stepClock();
        checkOutput("rstReady", longint'(ready), 1, 0);
        checkOutput("rstValid", longint'(valid), 0, 0);
        checkOutput("rstAng", longint'(angOut), 0, 0);
        checkOutput("rstMag", longint'(magOut), 0, 0);
        reset = 1'b0;
        stepClock();

        runVector("unitX", 32'sh40000000, 32'sh00000000, 0, 64, 64);
        runVector("diag45", 32'sh2D413CCD, 32'sh2D413CCD, 64'sh03243F6A9, 64, 64);
        runVector("negY", 32'sh00000000, 32'shC0000000, -64'sh6487ED51, 64, 64);
        runVector("negX", 32'shC0000000, 32'sh00000000, PI_LSB, 64, 64);
        runVector("zero", 32'sh00000000, 32'sh00000000, 0, 0, 0);
        runVector("minXY", 32'sh80000000, 32'sh80000000, radToLsb(-0.75 * PI_R), 64, 64);
        runVector("minX", 32'sh80000000, 32'sh00000000, PI_LSB, 64, 64);
        runVector("q2", 32'shE0000000, 32'sh376CF5D1, radToLsb(2.0 * PI_R / 3.0), 64, 64);

        // Reset mid-iteration aborts the job without a valid pulse.
        applyStimulus(32'sh40000000, 32'sh40000000);
        repeat (10) stepClock();
        reset = 1'b1;
        stepClock();
        reset = 1'b0;
        checkOutput("abortReady", longint'(ready), 1, 0);
        checkOutput("abortValid", longint'(valid), 0, 0);
        seen = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            stepClock();
            if (valid) seen++;
        end
        checkOutput("abortNoValid", longint'(seen), 0, 0);
        runVector("postAbort", 32'sh2D413CCD, 32'sh2D413CCD, 64'sh03243F6A9, 64, 64);

        // A start while busy is ignored and not queued.
        applyStimulus(32'sh00000000, 32'sh40000000);
        repeat (3) stepClock();
        checkOutput("busyReady", longint'(ready), 0, 0);
        xIn   = 32'shC0000000;
        yIn   = 32'sh00000000;
        start = 1'b1;
        stepClock();
        start = 1'b0;
        waitValid(lat);
        checkOutput("busyLat", longint'(lat), longint'(LAT - 4), 0);
        checkOutput("busyAng", longint'(angOut), 64'sh6487ED51, 64);
        seen = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            stepClock();
            if (valid) seen++;
        end
        checkOutput("busyNoQueue", longint'(seen), 0, 0);

        // Start held high: one result per PERIOD cycles.
        xIn   = '0;
        yIn   = '0;
        start = 1'b1;
        seen     = 0;
        firstAt  = -1;
        secondAt = -1;
        for (int i = 1; i <= 3 * PERIOD + 1; i++) begin
            stepClock();
            if (valid) begin
                seen++;
                if (firstAt < 0) firstAt = i;
                else if (secondAt < 0) secondAt = i;
                checkOutput("b2bAng", longint'(angOut), 0, 0);
                checkOutput("b2bMag", longint'(magOut), 0, 0);
            end
        end
        start = 1'b0;
        checkOutput("b2bCount", longint'(seen), 3, 0);
        checkOutput("b2bSpacing", longint'(secondAt - firstAt), longint'(PERIOD), 0);
        waitValid(lat);
        stepClock();

        // Sweep of unit vectors at 5 degree steps; angle compared modulo 2pi.
        for (int k = 0; k < 72; k++) begin
            rad    = real'(k) * 5.0 * PI_R / 180.0;
            xv     = WIDTH'(longint'($cos(rad) * SCALE));
            yv     = WIDTH'(longint'($sin(rad) * SCALE));
            angExp = radToLsb(rad);
            applyStimulus(xv, yv);
            waitValid(lat);
            checkOutput($sformatf("sweepLat%0d", k), longint'(lat), longint'(LAT), 0);
            diff = longint'(angOut) - angExp;
            if (diff > PI_LSB) diff = diff - 2 * PI_LSB;
            if (diff < -PI_LSB) diff = diff + 2 * PI_LSB;
            checkOutput($sformatf("sweepAng%0d", k), angExp + diff, angExp, 128);
            checkOutput($sformatf("sweepMag%0d", k), longint'(magOut), expMag(xv, yv), 128);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
